mem_responder: RTL and testbench

- Single-port data/instruction memory responder that serves load/store requests issued by the cpu core over a valid/ready request/response bus.
- Sits on the core's memory interface and is the target end of that bus: the core initiates, this block accepts, waits a programmable latency, performs the access and returns a response.
- Used in the core-level bench and the top level; inserts configurable wait states to stress the core's stall logic.

---
 rtl/mem_responder.sv | 175 +++++++++++++++++
 tb/tb_mem_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-port load/store memory target on a valid/ready
// request/response bus. Accepts one request at a time, waits WAIT_CYCLES,
// performs the access, then holds the response until the core takes it.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_we                   1 = store, 0 = load
//   req_addr                 byte address
//   req_wdata/req_wstrb      store data and byte-lane enables
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata                load data (0 for stores and errors)
//   rsp_err                  misaligned or out-of-range access
module mem_responder #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = ADDR_W - OFF_W;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              we_q,        we_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic [STRB_W-1:0] wstrb_q,     wstrb_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;

  logic [IDX_W-1:0]  word_idx_c;
  logic [MEM_AW-1:0] mem_idx_c;
  logic              align_err_c;
  logic              range_err_c;
  logic              mem_we_c;

  // Decode the captured address into word index and error flags.
  assign word_idx_c  = addr_q[ADDR_W-1:OFF_W];
  assign mem_idx_c   = MEM_AW'(word_idx_c);
  assign align_err_c = (ADDR_W'(addr_q & ADDR_W'(STRB_W - 1)) != '0);
  assign range_err_c = (32'(word_idx_c) >= 32'(DEPTH));

  // State, captured request and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          wstrb_d     = req_wstrb;
          cnt_d       = CNT_W'(WAIT_CYCLES);
          req_ready_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Access happens on this edge; the response is registered with it.
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          if (align_err_c || range_err_c) begin
            rsp_err_d = 1'b1;
          end else if (we_q) begin
            mem_we_c = 1'b1;
          end else begin
            rsp_rdata_d = mem[mem_idx_c];
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
    endcase
  end

  // Byte-lane store into the array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int i = 0; i < int'(STRB_W); i++) begin
        if (wstrb_q[i]) begin
          mem[mem_idx_c][i*8 +: 8] <= wdata_q[i*8 +: 8];
        end
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: instance 0 built with WAIT_CYCLES=2, instance 1
// with WAIT_CYCLES=0. Directed steps followed by random traffic checked
// against a word-array reference model.
module tb_mem_responder;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [15:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wstrb [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic [31:0] mdl [2][DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  function automatic int unsigned wc(input int s);
    return (s == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: the memory is an array of words, errors leave it untouched.
  task automatic model(input int s, input logic we, input logic [15:0] addr,
                       input logic [31:0] wd, input logic [3:0] ws,
                       output logic err, output logic [31:0] rd);
    int unsigned idx;
    idx = int'(addr) / 4;
    err = (int'(addr) % 4 != 0) || (idx >= DEPTH);
    rd  = 32'h0;
    if (!err) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (ws[b]) mdl[s][idx][b*8 +: 8] = wd[b*8 +: 8];
      end else begin
        rd = mdl[s][idx];
      end
    end
  endtask

  task automatic check_reset_vals(input int s, input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready[s]), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid[s]), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata[s], 32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err[s]), 32'd0);
  endtask

  // One complete transaction; entered and left #1 after a rising edge.
  task automatic xact(input int s, input logic we, input logic [15:0] addr,
                      input logic [31:0] wd, input logic [3:0] ws, input int stall,
                      output logic [31:0] rd_obs, output logic err_obs,
                      output int unsigned acc_cyc);
    int n;
    logic exp_err;
    logic [31:0] exp_rd;
    n = 0;
    while (req_ready[s] !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready_wait", 32'(req_ready[s]), 32'd1);
    req_valid[s] = 1'b1; req_we[s] = we; req_addr[s] = addr;
    req_wdata[s] = wd;   req_wstrb[s] = ws;
    rsp_ready[s] = (stall == 0);
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid[s] = 1'b0;
    chk("req_ready_busy", 32'(req_ready[s]), 32'd0);
    model(s, we, addr, wd, ws, exp_err, exp_rd);
    n = 0;
    while (rsp_valid[s] !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", 32'(n), 32'(wc(s) + 1));
    chk("rsp_rdata", rsp_rdata[s], exp_rd);
    chk("rsp_err", 32'(rsp_err[s]), 32'(exp_err));
    rd_obs  = rsp_rdata[s];
    err_obs = rsp_err[s];
    for (int i = 0; i < stall; i++) begin
      // A competing store that must be ignored while the response waits.
      req_valid[s] = 1'b1; req_we[s] = 1'b1; req_addr[s] = 16'h0010;
      req_wdata[s] = 32'hFFFF_FFFF; req_wstrb[s] = 4'hF;
      @(posedge clk); #1;
      chk("stall_valid", 32'(rsp_valid[s]), 32'd1);
      chk("stall_rdata", rsp_rdata[s], exp_rd);
      chk("stall_err", 32'(rsp_err[s]), 32'(exp_err));
      chk("stall_req_ready", 32'(req_ready[s]), 32'd0);
    end
    req_valid[s] = 1'b0;
    rsp_ready[s] = 1'b1;
    @(posedge clk); #1;
    chk("hs_valid", 32'(rsp_valid[s]), 32'd0);
    chk("hs_req_ready", 32'(req_ready[s]), 32'd1);
    chk("hs_rdata", rsp_rdata[s], 32'd0);
    chk("hs_err", 32'(rsp_err[s]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int unsigned t0, t1;
    logic [15:0] a;
    int          s;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
      req_wdata[i] = '0;   req_wstrb[i] = '0; rsp_ready[i] = 1'b0;
    end
    #12;
    check_reset_vals(0, "rst0");
    check_reset_vals(1, "rst1");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Full store then readback.
    xact(0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, rd, er, t0);
    chk("store_err", 32'(er), 32'd0);
    xact(0, 1'b0, 16'h0010, 32'h0, 4'h0, 0, rd, er, t0);
    chk("load_deadbeef", rd, 32'hDEADBEEF);

    // Partial store on lanes 0 and 2.
    xact(0, 1'b1, 16'h0010, 32'h11223344, 4'b0101, 0, rd, er, t0);
    xact(0, 1'b0, 16'h0010, 32'h0, 4'h0, 0, rd, er, t0);
    chk("partial_store", rd, 32'hDE22BE44);

    // Error cases.
    xact(0, 1'b0, 16'h0012, 32'h0, 4'h0, 0, rd, er, t0);
    chk("misalign_err", 32'(er), 32'd1);
    chk("misalign_rdata", rd, 32'd0);
    xact(0, 1'b0, 16'h1000, 32'h0, 4'h0, 0, rd, er, t0);
    chk("range_err", 32'(er), 32'd1);
    chk("range_rdata", rd, 32'd0);
    xact(0, 1'b1, 16'h0011, 32'h55555555, 4'hF, 0, rd, er, t0);
    chk("misalign_store_err", 32'(er), 32'd1);
    xact(0, 1'b0, 16'h0010, 32'h0, 4'h0, 0, rd, er, t0);
    chk("after_bad_store", rd, 32'hDE22BE44);

    // Zero-strobe store is a legal no-op.
    xact(0, 1'b1, 16'h0010, 32'h0, 4'h0, 0, rd, er, t0);
    chk("wstrb0_err", 32'(er), 32'd0);

    // Backpressure for 5 cycles, then verify the ignored store left no trace.
    xact(0, 1'b0, 16'h0010, 32'h0, 4'h0, 5, rd, er, t0);
    xact(0, 1'b0, 16'h0010, 32'h0, 4'h0, 0, rd, er, t0);
    chk("after_backpressure", rd, 32'hDE22BE44);

    // Reset during WAIT aborts a pending store.
    xact(0, 1'b1, 16'h0020, 32'h01234567, 4'hF, 0, rd, er, t0);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 16'h0020;
    req_wdata[0] = 32'hCAFEF00D; req_wstrb[0] = 4'hF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("pre_abort_busy", 32'(req_ready[0]), 32'd0);
    rst = 1'b1;
    #1;
    check_reset_vals(0, "midrst");
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    xact(0, 1'b0, 16'h0020, 32'h0, 4'h0, 0, rd, er, t0);
    chk("abort_prior_contents", rd, 32'h01234567);

    // Back-to-back spacing on both builds.
    xact(0, 1'b0, 16'h0020, 32'h0, 4'h0, 0, rd, er, t0);
    xact(0, 1'b0, 16'h0010, 32'h0, 4'h0, 0, rd, er, t1);
    chk("spacing_w2", t1 - t0, 32'd5);
    xact(1, 1'b1, 16'h0030, 32'hA5A5_0001, 4'hF, 0, rd, er, t0);
    xact(1, 1'b1, 16'h0034, 32'h5A5A_0002, 4'hF, 0, rd, er, t0);
    xact(1, 1'b0, 16'h0030, 32'h0, 4'h0, 0, rd, er, t0);
    chk("w0_load_a", rd, 32'hA5A5_0001);
    xact(1, 1'b0, 16'h0034, 32'h0, 4'h0, 0, rd, er, t1);
    chk("w0_load_b", rd, 32'h5A5A_0002);
    chk("spacing_w0", t1 - t0, 32'd3);

    // Random traffic over a small word window on both builds.
    for (int i = 0; i < 8; i++) begin
      xact(0, 1'b1, 16'(16'h0100 + i*4), $urandom, 4'hF, 0, rd, er, t0);
      xact(1, 1'b1, 16'(16'h0100 + i*4), $urandom, 4'hF, 0, rd, er, t0);
    end
    for (int i = 0; i < 60; i++) begin
      s = int'($urandom_range(0, 1));
      a = 16'(16'h0100 + $urandom_range(0, 7) * 4);
      case ($urandom_range(0, 7))
        0: a = a | 16'($urandom_range(1, 3));
        1: a = a + 16'h1000;
        default: ;
      endcase
      xact(s, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
           int'($urandom_range(0, 2)), rd, er, t0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
